// File: rtl/change_logger_pkg.sv
// change_logger_pkg: shared default widths, FSM states and log entry layout
package change_logger_pkg;
   localparam int DEF_DATA_W = 4;
   localparam int DEF_TS_W   = 16;
   localparam int DEF_DEPTH  = 8;
   typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;
   typedef struct packed {
      logic [DEF_TS_W-1:0]   ts;
      logic [DEF_DATA_W-1:0] data;
   } entry_t;
endpackage

// File: rtl/change_logger_sync_fifo.sv
// sync_fifo: first-word fall-through FIFO that accepts a push when full if a pop happens alongside
module sync_fifo #(
   parameter int W     = 20,
   parameter int DEPTH = 8,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear_i,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] data_i,
   output logic [W-1:0] data_o,
   output logic         full_o,
   output logic         empty_o,
   output logic [AW:0]  count_o
);
   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0]   count_q;
   logic          do_pop, do_push;
   assign empty_o = count_q == '0;
   assign full_o  = count_q == (AW+1)'(DEPTH);
   assign do_pop  = pop_i && !empty_o && !clear_i;
   assign do_push = push_i && (!full_o || do_pop) && !clear_i;
   assign data_o  = empty_o ? '0 : mem_q[rd_q];
   assign count_o = count_q;
   // pointers wrap naturally; occupancy is tracked in its own counter
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else if (clear_i) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + AW'(1);
         if (do_pop) rd_q <= rd_q + AW'(1);
         count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   // storage needs no reset; the count alone decides what is valid
   always_ff @(posedge clk)
      if (do_push) mem_q[wr_q] <= data_i;
endmodule

// File: rtl/change_logger.sv
// change_logger: timestamps every change on din and queues it for a valid/ready reader
module change_logger
   import change_logger_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int TS_W   = DEF_TS_W,
   parameter int DEPTH  = DEF_DEPTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   clear,
   input  logic [DATA_W-1:0]      din,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_W-1:0]      out_data,
   output logic [TS_W-1:0]        out_ts,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow
);
   state_t                 state_q;
   logic [TS_W-1:0]        ts_q;
   logic [DATA_W-1:0]      last_q;
   logic                   overflow_q, push, pop, drop, full, empty;
   logic [TS_W+DATA_W-1:0] head;
   assign push      = en && !clear && (state_q == PRIME || (state_q == RUN && din != last_q));
   assign pop       = out_valid && out_ready;
   assign drop      = push && full && !pop;
   assign out_valid = !empty;
   assign {out_ts, out_data} = head;
   assign overflow  = overflow_q;
   sync_fifo #(.W(TS_W + DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .clear_i (clear),
      .push_i  (push),
      .pop_i   (pop),
      .data_i  ({ts_q, din}),
      .data_o  (head),
      .full_o  (full),
      .empty_o (empty),
      .count_o (count)
   );
   // capture FSM with timestamp, last-value tracking and sticky drop flag
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q    <= IDLE;
         ts_q       <= '0;
         last_q     <= '0;
         overflow_q <= 1'b0;
      end else if (clear) begin
         state_q    <= IDLE;
         ts_q       <= '0;
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= overflow_q | drop;
         case (state_q)
            IDLE:  if (en) state_q <= PRIME;
            PRIME: if (en) begin
                      last_q  <= din;
                      ts_q    <= ts_q + TS_W'(1);
                      state_q <= RUN;
                   end else state_q <= IDLE;
            RUN:   if (en) begin
                      last_q <= din;
                      ts_q   <= ts_q + TS_W'(1);
                   end else state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
endmodule

// File: doc/change_logger.md
Name: change_logger

Overview:
- Hardware counterpart of a stimulus driver: watches a narrow data bus and logs every value change with a timestamp.
- Entries are buffered in an internal FIFO and drained by a downstream reader over a valid/ready interface.
- Sits on the output side of a block under test, for on-chip capture of the response bus.

Parameters:
- DATA_W, 4: width of the monitored bus.
- TS_W, 16: width of the free-running timestamp counter.
- DEPTH, 8: FIFO entries; must be a power of 2, minimum 2.

Ports:
- clk  in  1  single clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  capture enable; level-sensitive.
- clear  in  1  synchronous flush; priority over all other events except rst.
- din  in  DATA_W  monitored bus, synchronous to clk.
- out_valid  out  1  FIFO head entry available.
- out_ready  in  1  reader accepts the head entry.
- out_data  out  DATA_W  logged value at head.
- out_ts  out  TS_W  timestamp of the logged value at head.
- count  out  $clog2(DEPTH)+1  current number of entries.
- overflow  out  1  sticky; an event was dropped because the FIFO was full.

Behaviour:
- Reset (rst=1, async):
  - All outputs 0 and FIFO empty.
  - ts=0, last value register=0.
  - FSM enters IDLE.
- FSM states: IDLE, PRIME, RUN.
  - IDLE: ts holds. en=1 -> PRIME.
  - PRIME: lasts one edge. Unconditionally logs {din, ts}, loads last<=din, ts increments, -> RUN. en=0 in PRIME -> IDLE with no log.
  - RUN: each edge, ts<=ts+1. Event when din != last: log {din, ts}, last<=din. en=0 -> IDLE; ts and last hold.
- Timestamp:
  - Unsigned, wraps from 2^TS_W-1 to 0 with no flag.
  - A logged ts is the counter value before the capturing edge.
- Latency: event at edge k gives out_valid=1 after edge k, i.e. first-word fall-through.
- FIFO:
  - Pop when out_valid && out_ready.
  - Push accepted if count<DEPTH, or if count==DEPTH and a pop occurs the same cycle.
  - Push and pop in the same cycle: count unchanged.
  - Push rejected: entry dropped, overflow<=1, last still updates (so a held value is not re-logged).
  - Pop with empty FIFO: ignored.
- out_data/out_ts:
  - Stable while out_valid && !out_ready.
  - Value is don't-care when out_valid=0; implementation drives 0.
- Pointers: log2(DEPTH) bits, wrap naturally; count is tracked separately.
- clear=1:
  - Empties FIFO, clears overflow, sets ts=0, FSM -> IDLE.
  - No push or pop that cycle.
  - If en is still 1, the next edge enters PRIME and re-logs the current din.
- rst asserted mid-operation: immediate flush; no partial entry survives.

Decomposition:
- Shared package: default widths (DATA_W, TS_W, DEPTH), FSM state enum (IDLE, PRIME, RUN), and an entry struct/typedef {ts, data} of width TS_W+DATA_W.
- Sub-module sync_fifo, generic over width and depth:
  - Push/pop/full/empty/count ports.
  - Push accepted when full if a pop occurs the same cycle.
  - Async active-high rst plus sync clear.
- change_logger holds the FSM, ts counter, last-value register, change detect and overflow flag.

Test Plan:
- Basic change log:
  - Stimulus: rst pulse, en=1, din=4'b1010; at ts=50 din=4'b1100; at ts=150 din=4'b0000; out_ready=1.
  - Response: exactly three entries, in order: {1010,ts 0}, {1100,ts 50}, {0000,ts 150}; no extra entries while din is held.
- Overflow:
  - Stimulus: out_ready=0, din toggles 1010/0101 every cycle for 12 cycles.
  - Response: count saturates at 8, overflow=1, the 8 oldest entries are retained, and popping yields ts 0..7 in order.
- Full with simultaneous push/pop:
  - Stimulus: FIFO full, out_ready=1 on the same cycle as a new change.
  - Response: push accepted, count stays 8, overflow stays 0.
- Enable gating:
  - Stimulus: en=0 for 20 cycles while din changes.
  - Response: no entries and ts frozen. Re-asserting en logs current din once (PRIME) with ts equal to the held value.
- clear mid-run:
  - Stimulus: 3 entries queued, overflow=1, then clear=1 for one cycle.
  - Response: count=0, out_valid=0, overflow=0, ts=0. The next edge with en=1 logs current din at ts 0.
- Wrap and async reset:
  - Stimulus: TS_W=4, din changes at 15 and 17 edges after PRIME.
  - Response: logged ts are 15 and 1.
  - Then: rst asserted between edges with entries queued. Response: out_valid drops immediately, count=0.
